// File: rtl/lbp_window_sched.sv
// ---------------------------------------------------------------------------
// lbp_window_sched
//
// Address scheduler for a 3x3 LBP window scan over a square grayscale image
// of side 2**SIDE_LOG2 pixels.  Every interior pixel becomes a window centre
// once, in raster order.  The first window of each row is fetched in full
// (9 reads).  Every later window in that row reuses the previous one: the
// datapath shifts its columns left and only the new right-hand column
// (slots 2, 5, 8) is fetched.
//
// Ports
//   clk         single clock, rising edge
//   reset       asynchronous, active-low reset
//   gray_ready  image memory available (level); stalls issue while low
//   gray_req    read request, gray_addr valid while high
//   gray_addr   read address {row, col}; holds the last issued address
//               whenever no read is being issued
//   pix_we      returned pixel valid this cycle (issue delayed one cycle)
//   pix_idx     window slot 0..8 of the returned pixel
//   win_shift   one-cycle pulse telling the datapath to shift columns left
//   win_valid   complete window available, held until dp_ready
//   dp_ready    datapath accepts the window
//   ctr_addr    centre pixel address {r, c}, valid with win_valid
//   finish      sticky frame-done flag
// ---------------------------------------------------------------------------
module lbp_window_sched #(
    parameter int SIDE_LOG2 = 7
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   gray_ready,
    output logic                   gray_req,
    output logic [2*SIDE_LOG2-1:0] gray_addr,
    output logic                   pix_we,
    output logic [3:0]             pix_idx,
    output logic                   win_shift,
    output logic                   win_valid,
    input  logic                   dp_ready,
    output logic [2*SIDE_LOG2-1:0] ctr_addr,
    output logic                   finish
);

    // Last interior row/column index (126 for a 128x128 image).
    localparam logic [SIDE_LOG2-1:0] LAST = SIDE_LOG2'((1 << SIDE_LOG2) - 2);
    localparam logic [SIDE_LOG2-1:0] ONE  = SIDE_LOG2'(1);

    typedef enum logic [2:0] {
        IDLE,
        ROW_FILL,
        COL_FILL,
        DRAIN,
        EMIT,
        DONE
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [SIDE_LOG2-1:0]     r;
    logic [SIDE_LOG2-1:0]     c;
    logic [3:0]               k;
    logic [2*SIDE_LOG2-1:0]   addr_hold;
    logic [SIDE_LOG2-1:0]     dy;
    logic [SIDE_LOG2-1:0]     dx;
    logic [SIDE_LOG2-1:0]     row_a;
    logic [SIDE_LOG2-1:0]     col_a;
    logic                     filling;
    logic                     issue;
    logic                     last_slot;

    assign filling   = (state == ROW_FILL) || (state == COL_FILL);
    assign issue     = filling && gray_ready;
    assign last_slot = (k == 4'd8);

    // Split slot index k = 3*dy + dx into its row and column offsets.
    always_comb begin
        dy = '0;
        dx = '0;
        case (k)
            4'd0, 4'd1, 4'd2: dy = SIDE_LOG2'(0);
            4'd3, 4'd4, 4'd5: dy = SIDE_LOG2'(1);
            default:          dy = SIDE_LOG2'(2);
        endcase
        case (k)
            4'd0, 4'd3, 4'd6: dx = SIDE_LOG2'(0);
            4'd1, 4'd4, 4'd7: dx = SIDE_LOG2'(1);
            default:          dx = SIDE_LOG2'(2);
        endcase
    end

    // The window's top-left corner is (r-1, c-1); r and c are never 0 while
    // a read is issued, so these subtractions stay in range.
    assign row_a = r + dy - ONE;
    assign col_a = c + dx - ONE;

    // A stalled or idle cycle keeps showing the last issued address, so the
    // bus only changes when a new read actually goes out.
    assign gray_addr = issue ? {row_a, col_a} : addr_hold;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and the state-decoded outputs.
    always_comb begin
        state_nxt = state;
        gray_req  = 1'b0;
        win_shift = 1'b0;
        win_valid = 1'b0;
        finish    = 1'b0;
        ctr_addr  = '0;
        case (state)
            IDLE: begin
                if (gray_ready) begin
                    state_nxt = ROW_FILL;
                end
            end
            ROW_FILL, COL_FILL: begin
                gray_req = issue;
                // Slot 2 is the first new column read of a reused window;
                // the datapath must shift before that pixel lands.
                win_shift = issue && (state == COL_FILL) && (k == 4'd2);
                if (issue && last_slot) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                state_nxt = EMIT;
            end
            EMIT: begin
                win_valid = 1'b1;
                ctr_addr  = {r, c};
                if (dp_ready) begin
                    if (c != LAST) begin
                        state_nxt = COL_FILL;
                    end else if (r != LAST) begin
                        state_nxt = ROW_FILL;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                finish = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Scan counters, slot counter, address hold and the one-cycle return
    // pipeline.  Reset clears the return stage so a read in flight at abort
    // never produces a pix_we.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r         <= '0;
            c         <= '0;
            k         <= '0;
            addr_hold <= '0;
            pix_we    <= 1'b0;
            pix_idx   <= '0;
        end else begin
            pix_we    <= gray_req;
            pix_idx   <= k;
            addr_hold <= gray_addr;
            case (state)
                IDLE: begin
                    if (gray_ready) begin
                        r <= ONE;
                        c <= ONE;
                        k <= 4'd0;
                    end
                end
                ROW_FILL: begin
                    if (issue && !last_slot) begin
                        k <= k + 4'd1;
                    end
                end
                COL_FILL: begin
                    if (issue && !last_slot) begin
                        k <= k + 4'd3;
                    end
                end
                EMIT: begin
                    if (dp_ready) begin
                        if (c != LAST) begin
                            c <= c + ONE;
                            k <= 4'd2;
                        end else if (r != LAST) begin
                            r <= r + ONE;
                            c <= ONE;
                            k <= 4'd0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lbp_window_sched.sv
// ---------------------------------------------------------------------------
// tb_lbp_window_sched
//
// Directed scenarios for reset, the first row fill, EMIT hold, the column
// reuse fill, a gray_ready stall and a mid-frame reset, followed by a full
// 128x128 frame with randomised readies checked against a window-level
// reference model.
// ---------------------------------------------------------------------------
module tb_lbp_window_sched;

    logic        clk        = 1'b0;
    logic        reset      = 1'b0;
    logic        gray_ready = 1'b0;
    logic        dp_ready   = 1'b0;
    logic        gray_req;
    logic [13:0] gray_addr;
    logic        pix_we;
    logic [3:0]  pix_idx;
    logic        win_shift;
    logic        win_valid;
    logic [13:0] ctr_addr;
    logic        finish;

    int checks = 0;
    int errors = 0;

    int exp_row[9] = '{0, 1, 2, 128, 129, 130, 256, 257, 258};
    int exp_col[3] = '{3, 131, 259};

    lbp_window_sched #(.SIDE_LOG2(7)) dut (
        .clk        (clk),
        .reset      (reset),
        .gray_ready (gray_ready),
        .gray_req   (gray_req),
        .gray_addr  (gray_addr),
        .pix_we     (pix_we),
        .pix_idx    (pix_idx),
        .win_shift  (win_shift),
        .win_valid  (win_valid),
        .dp_ready   (dp_ready),
        .ctr_addr   (ctr_addr),
        .finish     (finish)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Image address of window slot k around centre (r, c).
    function automatic int addr_of(int r, int c, int k);
        return (r - 1 + k / 3) * 128 + (c - 1 + k % 3);
    endfunction

    // All outputs must be zero while reset is held, even with readies high.
    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0; gray_ready = 1'b1; dp_ready = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            checks++;
            if ({gray_req, pix_we, pix_idx, win_shift, win_valid, finish} !== 9'b0) begin
                errors++;
                $display("[TB] FAIL reset_ctrl: got %b expected 0", {gray_req, pix_we, pix_idx, win_shift, win_valid, finish});
            end
            checks++;
            if (gray_addr !== 14'd0 || ctr_addr !== 14'd0) begin
                errors++;
                $display("[TB] FAIL reset_addr: got gray_addr=%0d ctr_addr=%0d expected 0/0", gray_addr, ctr_addr);
            end
        end
    endtask

    // First window: nine reads in slot order, drain, then the window.
    task automatic test_row_fill();
        @(negedge clk);
        reset = 1'b1; gray_ready = 1'b1; dp_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk); #1;
            checks++;
            if (gray_req !== 1'b1 || gray_addr !== 14'(exp_row[i]) || win_shift !== 1'b0) begin
                errors++;
                $display("[TB] FAIL row_fill_issue[%0d]: got req=%b addr=%0d shift=%b expected 1/%0d/0", i, gray_req, gray_addr, win_shift, exp_row[i]);
            end
            checks++;
            if (pix_we !== 1'(i > 0) || (i > 0 && pix_idx !== 4'(i - 1))) begin
                errors++;
                $display("[TB] FAIL row_fill_return[%0d]: got we=%b idx=%0d expected %b/%0d", i, pix_we, pix_idx, i > 0, i - 1);
            end
        end
        @(negedge clk); #1;
        checks++;
        if (gray_req !== 1'b0 || pix_we !== 1'b1 || pix_idx !== 4'd8 || win_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL row_fill_drain: got req=%b we=%b idx=%0d valid=%b expected 0/1/8/0", gray_req, pix_we, pix_idx, win_valid);
        end
        @(negedge clk); #1;
        checks++;
        if (win_valid !== 1'b1 || ctr_addr !== 14'd129 || pix_we !== 1'b0 || gray_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL row_fill_emit: got valid=%b ctr=%0d we=%b req=%b expected 1/129/0/0", win_valid, ctr_addr, pix_we, gray_req);
        end
    endtask

    // Window must be held unchanged with no memory traffic while unaccepted.
    task automatic test_emit_hold();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            checks++;
            if ({win_valid, ctr_addr, gray_req, pix_we, win_shift} !== {1'b1, 14'd129, 3'b000}) begin
                errors++;
                $display("[TB] FAIL emit_hold[%0d]: got valid=%b ctr=%0d req=%b we=%b shift=%b expected 1/129/0/0/0", i, win_valid, ctr_addr, gray_req, pix_we, win_shift);
            end
        end
    endtask

    // Accept the first window; the next one reuses it and fetches one column.
    task automatic test_col_fill();
        @(negedge clk);
        dp_ready = 1'b1; #1;
        checks++;
        if (win_valid !== 1'b1 || ctr_addr !== 14'd129) begin
            errors++;
            $display("[TB] FAIL col_fill_accept: got valid=%b ctr=%0d expected 1/129", win_valid, ctr_addr);
        end
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            dp_ready = 1'b0; #1;
            checks++;
            if (gray_req !== 1'b1 || gray_addr !== 14'(exp_col[j]) || win_shift !== 1'(j == 0)) begin
                errors++;
                $display("[TB] FAIL col_fill_issue[%0d]: got req=%b addr=%0d shift=%b expected 1/%0d/%b", j, gray_req, gray_addr, win_shift, exp_col[j], j == 0);
            end
            checks++;
            if (pix_we !== 1'(j > 0) || (j > 0 && pix_idx !== 4'(3 * j - 1))) begin
                errors++;
                $display("[TB] FAIL col_fill_return[%0d]: got we=%b idx=%0d expected %b/%0d", j, pix_we, pix_idx, j > 0, 3 * j - 1);
            end
        end
        @(negedge clk); #1;
        checks++;
        if (pix_we !== 1'b1 || pix_idx !== 4'd8 || win_shift !== 1'b0 || gray_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL col_fill_drain: got we=%b idx=%0d shift=%b req=%b expected 1/8/0/0", pix_we, pix_idx, win_shift, gray_req);
        end
        @(negedge clk); #1;
        checks++;
        if (win_valid !== 1'b1 || ctr_addr !== 14'd130) begin
            errors++;
            $display("[TB] FAIL col_fill_emit: got valid=%b ctr=%0d expected 1/130", win_valid, ctr_addr);
        end
    endtask

    // gray_ready dropped for five cycles right after slot 4 has issued.
    task automatic test_gray_stall();
        @(negedge clk);
        reset = 1'b0; gray_ready = 1'b0; dp_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1; gray_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            checks++;
            if (gray_req !== 1'b1 || gray_addr !== 14'(exp_row[i])) begin
                errors++;
                $display("[TB] FAIL stall_pre[%0d]: got req=%b addr=%0d expected 1/%0d", i, gray_req, gray_addr, exp_row[i]);
            end
        end
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            gray_ready = 1'b0; #1;
            checks++;
            if (gray_req !== 1'b0 || gray_addr !== 14'd129) begin
                errors++;
                $display("[TB] FAIL stall_hold[%0d]: got req=%b addr=%0d expected 0/129", s, gray_req, gray_addr);
            end
            checks++;
            if (pix_we !== 1'(s == 0) || (s == 0 && pix_idx !== 4'd4)) begin
                errors++;
                $display("[TB] FAIL stall_return[%0d]: got we=%b idx=%0d expected %b/4", s, pix_we, pix_idx, s == 0);
            end
        end
        @(negedge clk);
        gray_ready = 1'b1; #1;
        checks++;
        if (gray_req !== 1'b1 || gray_addr !== 14'd130 || pix_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_resume: got req=%b addr=%0d we=%b expected 1/130/0", gray_req, gray_addr, pix_we);
        end
    endtask

    // Reset in the middle of a fill aborts at once and drops the read in flight.
    task automatic test_mid_reset();
        @(negedge clk); #1;
        checks++;
        if (gray_req !== 1'b1 || gray_addr !== 14'd256 || pix_we !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_reset_pre: got req=%b addr=%0d we=%b expected 1/256/1", gray_req, gray_addr, pix_we);
        end
        reset = 1'b0; #1;
        checks++;
        if ({gray_req, pix_we, win_shift, win_valid, finish} !== 5'b0 || gray_addr !== 14'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset_abort: got req=%b we=%b addr=%0d expected 0/0/0", gray_req, pix_we, gray_addr);
        end
        @(negedge clk); #1;
        checks++;
        if (pix_we !== 1'b0 || gray_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_discard: got we=%b req=%b expected 0/0", pix_we, gray_req);
        end
        @(negedge clk);
        reset = 1'b1; gray_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            checks++;
            if (gray_req !== 1'b1 || gray_addr !== 14'(i) || pix_we !== 1'(i == 1) || (i == 1 && pix_idx !== 4'd0)) begin
                errors++;
                $display("[TB] FAIL mid_reset_restart[%0d]: got req=%b addr=%0d we=%b idx=%0d expected 1/%0d/%b/0", i, gray_req, gray_addr, pix_we, pix_idx, i, i == 1);
            end
        end
    endtask

    // Whole frame with random readies against a window-level model: each
    // window is a list of slots to read, then one drain cycle, then the
    // centre is offered until accepted.  Stall cycles add to the ideal time.
    task automatic test_full_frame();
        int  mr, mc, phase, last_addr, prev_slot, hs, stalls, cycles, exp_addr, err0;
        bit  prev_issue, exp_shift, done;
        int  slots[$];
        @(negedge clk);
        reset = 1'b0; gray_ready = 1'b0; dp_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1; gray_ready = 1'b1;
        mr = 1; mc = 1; slots = {0, 1, 2, 3, 4, 5, 6, 7, 8};
        phase = 0; last_addr = 0; prev_issue = 0; prev_slot = 0;
        hs = 0; stalls = 0; cycles = 0; done = 0; err0 = errors;
        while (!done && cycles < 90000) begin
            @(negedge clk);
            gray_ready = ($urandom_range(31) != 0);
            dp_ready   = ($urandom_range(15) != 0);
            #1;
            checks++;
            if (pix_we !== prev_issue || (prev_issue && pix_idx !== 4'(prev_slot))) begin
                errors++;
                $display("[TB] FAIL frame_return r=%0d c=%0d: got we=%b idx=%0d expected %b/%0d", mr, mc, pix_we, pix_idx, prev_issue, prev_slot);
            end
            prev_issue = 0;
            case (phase)
                0: begin
                    exp_addr  = gray_ready ? addr_of(mr, mc, slots[0]) : last_addr;
                    exp_shift = gray_ready && mc != 1 && slots[0] == 2;
                    checks++;
                    if ({gray_req, win_shift, win_valid, finish} !== {gray_ready, exp_shift, 2'b00} || gray_addr !== 14'(exp_addr)) begin
                        errors++;
                        $display("[TB] FAIL frame_fill r=%0d c=%0d: got req=%b shift=%b valid=%b addr=%0d expected %b/%b/0/%0d", mr, mc, gray_req, win_shift, win_valid, gray_addr, gray_ready, exp_shift, exp_addr);
                    end
                    if (gray_ready) begin
                        last_addr  = exp_addr;
                        prev_issue = 1;
                        prev_slot  = slots.pop_front();
                        if (slots.size() == 0) phase = 1;
                    end else begin
                        stalls++;
                    end
                    cycles++;
                end
                1: begin
                    checks++;
                    if ({gray_req, win_shift, win_valid, finish} !== 4'b0) begin
                        errors++;
                        $display("[TB] FAIL frame_drain r=%0d c=%0d: got req=%b shift=%b valid=%b finish=%b expected 0", mr, mc, gray_req, win_shift, win_valid, finish);
                    end
                    phase = 2;
                    cycles++;
                end
                2: begin
                    checks++;
                    if ({win_valid, gray_req, win_shift, finish} !== 4'b1000 || ctr_addr !== 14'(mr * 128 + mc)) begin
                        errors++;
                        $display("[TB] FAIL frame_emit: got valid=%b req=%b ctr=%0d expected 1/0/%0d", win_valid, gray_req, ctr_addr, mr * 128 + mc);
                    end
                    cycles++;
                    if (dp_ready) begin
                        hs++;
                        if (mc < 126) begin
                            mc++;
                            slots = {2, 5, 8};
                            phase = 0;
                        end else if (mr < 126) begin
                            mr++;
                            mc = 1;
                            slots = {0, 1, 2, 3, 4, 5, 6, 7, 8};
                            phase = 0;
                        end else begin
                            phase = 3;
                        end
                    end else begin
                        stalls++;
                    end
                end
                default: begin
                    checks++;
                    if ({finish, win_valid, gray_req} !== 3'b100) begin
                        errors++;
                        $display("[TB] FAIL frame_finish: got finish=%b valid=%b req=%b expected 1/0/0", finish, win_valid, gray_req);
                    end
                    done = 1;
                end
            endcase
            if (errors - err0 > 20) begin
                checks++;
                errors++;
                $display("[TB] FAIL frame_abort: got %0d errors expected 0", errors - err0);
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL frame_timeout: got done=0 after %0d cycles expected done=1", cycles);
        end
        checks++;
        if (hs !== 15876) begin
            errors++;
            $display("[TB] FAIL frame_handshakes: got %0d expected 15876", hs);
        end
        checks++;
        if (cycles !== 80136 + stalls) begin
            errors++;
            $display("[TB] FAIL frame_cycles: got %0d expected %0d", cycles, 80136 + stalls);
        end
    endtask

    // finish is sticky and the block stays quiet whatever the readies do.
    task automatic test_done_sticky();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            gray_ready = 1'($urandom_range(1));
            dp_ready   = 1'($urandom_range(1));
            #1;
            checks++;
            if ({finish, gray_req, win_valid, pix_we} !== 4'b1000) begin
                errors++;
                $display("[TB] FAIL done_sticky[%0d]: got finish=%b req=%b valid=%b we=%b expected 1/0/0/0", i, finish, gray_req, win_valid, pix_we);
            end
        end
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_row_fill();
        test_emit_hold();
        test_col_fill();
        test_gray_stall();
        test_mid_reset();
        test_full_frame();
        test_done_sticky();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lbp_window_sched.md
LBP_WINDOW_SCHED -- requirements
Module: lbp_window_sched

Interface
REQ-001 The block SHALL have one parameter: SIDE_LOG2, default 7, log2 of the square image side (only 7, i.e. 128x128, is verified).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 gray_ready  input  1  image memory available; level.
REQ-005 gray_req  output  1  read request; the address on gray_addr is valid while high.
REQ-006 gray_addr  output  14  read address, {row[6:0], col[6:0]}.
REQ-007 pix_we  output  1  returned pixel valid on gray_data this cycle (one cycle after the issue).
REQ-008 pix_idx  output  4  window slot 0..8 of the returned pixel, valid with pix_we.
REQ-009 win_shift  output  1  one-cycle pulse: datapath shifts window columns left (slot 2->1->0, 5->4->3, 8->7->6).
REQ-010 win_valid  output  1  3x3 window complete in the datapath; held until accepted.
REQ-011 dp_ready  input  1  datapath accepts the window; handshake completes on win_valid && dp_ready.
REQ-012 ctr_addr  output  14  centre pixel address {r,c}; valid with win_valid.
REQ-013 finish  output  1  frame done; sticky.

Function
REQ-014 Slot map SHALL be: k=3*dy+dx, with dy,dx in 0..2; address = (r-1+dy)*128 + (c-1+dx).
REQ-015 Centres SHALL be scanned in raster order: r = 1..126 outer, c = 1..126 inner; border pixels are never centres.
REQ-016 The FSM SHALL have states IDLE, ROW_FILL, COL_FILL, DRAIN, EMIT, DONE.
REQ-017 IDLE -> ROW_FILL on the first clock edge with gray_ready=1; r=1, c=1.
REQ-018 ROW_FILL SHALL issue slots k=0..8 in order, one per cycle, with gray_req=1, then go to DRAIN.
REQ-019 COL_FILL SHALL issue slots 2, 5, 8 in order, then go to DRAIN.
REQ-020 win_shift SHALL pulse in the same cycle as the COL_FILL slot-2 issue, and in no other cycle.
REQ-021 In ROW_FILL and COL_FILL, if gray_ready=0 the block SHALL hold k and gray_addr, drive gray_req=0, and not advance. An outstanding read still returns.
REQ-022 pix_we and pix_idx SHALL be registered copies of (gray_req && issue) and k, delayed exactly one cycle.
REQ-023 DRAIN SHALL last exactly one cycle (the last pix_we), then go to EMIT.
REQ-024 EMIT SHALL drive win_valid=1 and ctr_addr={r,c}; both stay stable while dp_ready=0.
REQ-025 On an EMIT handshake, the FSM SHALL go as follows:
- c<126: c+1, COL_FILL.
- c=126, r<126: r+1, c=1, ROW_FILL.
- r=c=126: DONE.
REQ-026 DONE SHALL drive finish=1 from the cycle after the last handshake until reset. gray_req=0 and win_valid=0 in DONE; the block ignores gray_ready.
REQ-027 gray_req SHALL be 0 in IDLE, DRAIN, EMIT and DONE.
REQ-028 Arithmetic SHALL be unsigned. r, c and k never wrap, and no address outside 0..16383 is produced.
REQ-029 With gray_ready=dp_ready=1 throughout:
- each first-of-row window SHALL take 11 cycles;
- each other window SHALL take 5 cycles;
- the frame SHALL take 80136 cycles from leaving IDLE to finish rising.

Reset
REQ-030 While reset=0, the following SHALL hold:
- outputs: gray_req, gray_addr, pix_we, pix_idx, win_shift, win_valid, ctr_addr and finish all 0;
- state: FSM in IDLE; r, c and k cleared.
REQ-031 Reset asserted mid-frame SHALL abort immediately and discard pending pix_we. After release, the block SHALL restart from r=1, c=1 on the next gray_ready.

Verification
REQ-032 Reset, then gray_ready=1:
- gray_addr sequence SHALL be 0, 1, 2, 128, 129, 130, 256, 257, 258;
- then win_valid with ctr_addr=129.
REQ-033 After the first handshake (dp_ready=1):
- win_shift pulses with gray_addr=3, then 131, 259;
- the window then has ctr_addr=130.
REQ-034 End of row:
- the window at ctr_addr=254 (r=1, c=126) SHALL be followed by a ROW_FILL starting at gray_addr=128;
- the next window has ctr_addr=257.
REQ-035 dp_ready held 0 for 20 cycles in EMIT: win_valid and ctr_addr SHALL be stable, gray_req=0, and no pix_we occurs.
REQ-036 gray_ready dropped for 5 cycles after ROW_FILL slot 4: gray_req=0 and gray_addr held at 129. Slot 4 SHALL still return one cycle later, and issue resumes at slot 5.
REQ-037 Full frame with random dp_ready:
- exactly 15876 handshakes, with ctr_addr covering every interior pixel once, in raster order;
- finish=1 after ctr_addr=16254 is accepted;
- with both readies tied high, 80136 cycles.
